// File: rtl/video_pkg.sv
// Shared definitions for the video timing / test-pattern generator.
//   pattern_e   : pattern_sel encoding (bars, grey ramp, solid, checker)
//   COLOR_*     : 24-bit RGB constants, R[23:16] G[15:8] B[7:0]
//   bar_color() : colour of bar 0..7, left to right
package video_pkg;

  typedef enum logic [1:0] {
    PAT_BARS    = 2'd0,
    PAT_RAMP    = 2'd1,
    PAT_SOLID   = 2'd2,
    PAT_CHECKER = 2'd3
  } pattern_e;

  localparam int NUM_BARS = 8;

  localparam logic [23:0] COLOR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COLOR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COLOR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COLOR_GREEN   = 24'h00FF00;
  localparam logic [23:0] COLOR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COLOR_RED     = 24'hFF0000;
  localparam logic [23:0] COLOR_BLUE    = 24'h0000FF;
  localparam logic [23:0] COLOR_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = COLOR_WHITE;
      3'd1:    c = COLOR_YELLOW;
      3'd2:    c = COLOR_CYAN;
      3'd3:    c = COLOR_GREEN;
      3'd4:    c = COLOR_MAGENTA;
      3'd5:    c = COLOR_RED;
      3'd6:    c = COLOR_BLUE;
      default: c = COLOR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Horizontal / vertical raster counters and combinational sync decode.
//   clock, reset (async, active-high), enable (low holds counters at 0)
//   hcount      : 0..H_TOTAL-1, wraps
//   vcount      : 0..V_TOTAL-1, advances on each hcount wrap
//   hsync_raw   : 0 while hcount < H_SYNC
//   vsync_raw   : 0 while vcount < V_SYNC
//   de_raw      : active window (h_active && v_active)
//   h_active / v_active : horizontal / vertical active ranges
//   h_last_active / v_last_active : last active pixel / last active line
//   line_end    : hcount at H_TOTAL-1
//   frame_end   : line_end on the last line of the frame
// All decode outputs describe the current counter state; the caller
// registers them so every output carries the same one-clock latency.
module video_timing_counter #(
  parameter int H_TOTAL  = 800,
  parameter int H_SYNC   = 96,
  parameter int H_BACKP  = 48,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int V_SYNC   = 2,
  parameter int V_BACKP  = 33,
  parameter int V_ACTIVE = 480,
  parameter int HW       = $clog2(H_TOTAL),
  parameter int VW       = $clog2(V_TOTAL)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          hsync_raw,
  output logic          vsync_raw,
  output logic          de_raw,
  output logic          h_active,
  output logic          v_active,
  output logic          h_last_active,
  output logic          v_last_active,
  output logic          line_end,
  output logic          frame_end
);

  localparam int H_START = H_SYNC + H_BACKP;
  localparam int H_END   = H_START + H_ACTIVE;
  localparam int V_START = V_SYNC + V_BACKP;
  localparam int V_END   = V_START + V_ACTIVE;

  // Zero-extended copies so every decode compares at full integer width,
  // even when an active window end does not fit in the counter width.
  logic [31:0] h_ext;
  logic [31:0] v_ext;

  assign h_ext = 32'(hcount);
  assign v_ext = 32'(vcount);

  assign line_end      = (h_ext == H_TOTAL - 1);
  assign frame_end     = line_end && (v_ext == V_TOTAL - 1);
  assign hsync_raw     = !(h_ext < H_SYNC);
  assign vsync_raw     = !(v_ext < V_SYNC);
  assign h_active      = (h_ext >= H_START) && (h_ext < H_END);
  assign v_active      = (v_ext >= V_START) && (v_ext < V_END);
  assign h_last_active = (h_ext == H_END - 1);
  assign v_last_active = (v_ext == V_END - 1);
  assign de_raw        = h_active && v_active;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (!enable) begin
      // Abort immediately; the next run starts from the top of a frame.
      hcount <= '0;
      vcount <= '0;
    end else if (line_end) begin
      hcount <= '0;
      vcount <= frame_end ? '0 : vcount + 1'b1;
    end else begin
      hcount <= hcount + 1'b1;
    end
  end

endmodule

// File: rtl/video_syncgen_pattern.sv
// Video sync generator with built-in test patterns.
//   clock, reset (async, active-high)
//   enable      : run timing; low forces idle outputs and clears counters
//   pattern_sel : 0 colour bars, 1 grey ramp, 2 solid, 3 checker
//   solid_color : RGB for the solid pattern
//   vsync/hsync : active-low syncs
//   de          : active-high data enable
//   pixel       : RGB, zero outside the active window
//   frame_top   : one-clock pulse on the first output clock of each frame
// pattern_sel/solid_color are captured only at the top of a frame, so a
// change mid-frame shows up from the next frame. Every output is registered
// from the counter state of the previous clock.
module video_syncgen_pattern
  import video_pkg::*;
#(
  parameter int H_TOTAL  = 800,
  parameter int H_SYNC   = 96,
  parameter int H_BACKP  = 48,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int V_SYNC   = 2,
  parameter int V_BACKP  = 33,
  parameter int V_ACTIVE = 480
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_color,
  output logic        vsync,
  output logic        hsync,
  output logic        de,
  output logic [23:0] pixel,
  output logic        frame_top
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  // x needs at least 8 bits for the ramp; y at least 6 for the checker.
  localparam int XW = ($clog2(H_ACTIVE) > 8) ? $clog2(H_ACTIVE) : 8;
  localparam int YW = ($clog2(V_ACTIVE) > 6) ? $clog2(V_ACTIVE) : 6;
  localparam int BAR_W = H_ACTIVE / NUM_BARS;
  localparam int BW = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [BW-1:0] BAR_RELOAD = BW'(BAR_W - 1);

  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          hsync_raw;
  logic          vsync_raw;
  logic          de_raw;
  logic          h_active;
  logic          v_active;
  logic          h_last_active;
  logic          v_last_active;
  logic          line_end;
  logic          frame_end;
  logic          frame_start;

  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [2:0]    bar_idx_q;
  logic [BW-1:0] bar_cnt_q;
  pattern_e      pat_q;
  logic [23:0]   color_q;
  logic [23:0]   pixel_next;
  logic          x_advance;

  video_timing_counter #(
    .H_TOTAL  (H_TOTAL),
    .H_SYNC   (H_SYNC),
    .H_BACKP  (H_BACKP),
    .H_ACTIVE (H_ACTIVE),
    .V_TOTAL  (V_TOTAL),
    .V_SYNC   (V_SYNC),
    .V_BACKP  (V_BACKP),
    .V_ACTIVE (V_ACTIVE),
    .HW       (HW),
    .VW       (VW)
  ) u_timing (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .hcount        (hcount),
    .vcount        (vcount),
    .hsync_raw     (hsync_raw),
    .vsync_raw     (vsync_raw),
    .de_raw        (de_raw),
    .h_active      (h_active),
    .v_active      (v_active),
    .h_last_active (h_last_active),
    .v_last_active (v_last_active),
    .line_end      (line_end),
    .frame_end     (frame_end)
  );

  assign frame_start = (hcount == '0) && (vcount == '0);

  // x, bar_idx and bar_cnt move in lockstep with hcount so they describe
  // the same counter state as the sync decode. They sit at their
  // line-start values everywhere outside the active span, which makes
  // them correct on the first active pixel without any subtraction.
  assign x_advance = h_active && !h_last_active && !line_end;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_q       <= '0;
      bar_idx_q <= '0;
      bar_cnt_q <= BAR_RELOAD;
    end else if (!enable || !x_advance) begin
      x_q       <= '0;
      bar_idx_q <= '0;
      bar_cnt_q <= BAR_RELOAD;
    end else begin
      x_q <= x_q + 1'b1;
      if (bar_cnt_q == '0) begin
        bar_idx_q <= bar_idx_q + 1'b1;
        bar_cnt_q <= BAR_RELOAD;
      end else begin
        bar_cnt_q <= bar_cnt_q - 1'b1;
      end
    end
  end

  // y advances at the end of each active line and returns to 0 after the
  // last active line (and at frame wrap), ready for the next frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      y_q <= '0;
    end else if (!enable) begin
      y_q <= '0;
    end else if (line_end) begin
      if (v_active && !v_last_active && !frame_end) begin
        y_q <= y_q + 1'b1;
      end else begin
        y_q <= '0;
      end
    end
  end

  // Pattern selection is frozen for a whole frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pat_q   <= PAT_BARS;
      color_q <= '0;
    end else if (enable && frame_start) begin
      pat_q   <= pattern_e'(pattern_sel);
      color_q <= solid_color;
    end
  end

  always_comb begin
    pixel_next = COLOR_BLACK;
    if (de_raw) begin
      case (pat_q)
        PAT_BARS:    pixel_next = bar_color(bar_idx_q);
        PAT_RAMP:    pixel_next = {x_q[7:0], x_q[7:0], x_q[7:0]};
        PAT_SOLID:   pixel_next = color_q;
        PAT_CHECKER: pixel_next = (x_q[5] ^ y_q[5]) ? COLOR_BLACK : COLOR_WHITE;
        default:     pixel_next = COLOR_BLACK;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vsync     <= 1'b1;
      hsync     <= 1'b1;
      de        <= 1'b0;
      pixel     <= '0;
      frame_top <= 1'b0;
    end else if (!enable) begin
      vsync     <= 1'b1;
      hsync     <= 1'b1;
      de        <= 1'b0;
      pixel     <= '0;
      frame_top <= 1'b0;
    end else begin
      vsync     <= vsync_raw;
      hsync     <= hsync_raw;
      de        <= de_raw;
      pixel     <= pixel_next;
      frame_top <= frame_start;
    end
  end

endmodule

// File: tb/tb_video_syncgen_pattern.sv
// Directed bench for video_syncgen_pattern.
// Small raster: 20 clocks x 10 lines. A back porch of 2 lets
// sync + porch + 16 active pixels fill the 20-clock line exactly,
// giving a 200-clock frame with 16 active pixels per line.
// A second instance (64 active pixels, 36 active lines) carries the checker.
module tb_video_syncgen_pattern;

  localparam int H_TOTAL  = 20;
  localparam int H_SYNC   = 2;
  localparam int H_BACKP  = 2;
  localparam int H_ACTIVE = 16;
  localparam int V_TOTAL  = 10;
  localparam int V_SYNC   = 1;
  localparam int V_BACKP  = 2;
  localparam int V_ACTIVE = 6;
  localparam int FRAME    = H_TOTAL * V_TOTAL;

  localparam int C_H_TOTAL  = 80;
  localparam int C_H_SYNC   = 2;
  localparam int C_H_BACKP  = 3;
  localparam int C_H_ACTIVE = 64;
  localparam int C_V_TOTAL  = 40;
  localparam int C_V_SYNC   = 1;
  localparam int C_V_BACKP  = 2;
  localparam int C_V_ACTIVE = 36;
  localparam int C_FRAME    = C_H_TOTAL * C_V_TOTAL;

  localparam logic [27:0] IDLE = {4'b1100, 24'h000000};

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        enable;
  logic [1:0]  pattern_sel;
  logic [23:0] solid_color;
  logic        vsync, hsync, de, frame_top;
  logic [23:0] pixel;

  logic        enable2;
  logic [1:0]  pattern_sel2;
  logic [23:0] solid_color2;
  logic        vsync2, hsync2, de2, frame_top2;
  logic [23:0] pixel2;

  int compared   = 0;
  int mismatched = 0;
  int n1;
  int n2;
  logic [1:0]  f_pat;
  logic [23:0] f_col;
  logic [27:0] e;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  video_syncgen_pattern #(
    .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_BACKP(H_BACKP), .H_ACTIVE(H_ACTIVE),
    .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_BACKP(V_BACKP), .V_ACTIVE(V_ACTIVE)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .pattern_sel(pattern_sel), .solid_color(solid_color),
    .vsync(vsync), .hsync(hsync), .de(de), .pixel(pixel), .frame_top(frame_top)
  );

  video_syncgen_pattern #(
    .H_TOTAL(C_H_TOTAL), .H_SYNC(C_H_SYNC), .H_BACKP(C_H_BACKP), .H_ACTIVE(C_H_ACTIVE),
    .V_TOTAL(C_V_TOTAL), .V_SYNC(C_V_SYNC), .V_BACKP(C_V_BACKP), .V_ACTIVE(C_V_ACTIVE)
  ) dut_chk (
    .clock(clock), .reset(reset), .enable(enable2),
    .pattern_sel(pattern_sel2), .solid_color(solid_color2),
    .vsync(vsync2), .hsync(hsync2), .de(de2), .pixel(pixel2), .frame_top(frame_top2)
  );

  // Expected {vsync, hsync, de, frame_top, pixel} for output sample n of a run.
  function automatic logic [27:0] exp1(input int n, input logic [1:0] pat,
                                       input logic [23:0] col);
    int h, v, x, y;
    logic de_e;
    logic [23:0] p;
    logic [7:0] xb;
    h = n % H_TOTAL;
    v = (n / H_TOTAL) % V_TOTAL;
    x = h - (H_SYNC + H_BACKP);
    y = v - (V_SYNC + V_BACKP);
    de_e = (x >= 0) && (x < H_ACTIVE) && (y >= 0) && (y < V_ACTIVE);
    p = 24'h0;
    if (de_e) begin
      case (pat)
        2'd0: p = bars[x / (H_ACTIVE / 8)];
        2'd1: begin xb = 8'(x % 256); p = {xb, xb, xb}; end
        2'd2: p = col;
        default: p = ((((x / 32) + (y / 32)) % 2) == 1) ? 24'h000000 : 24'hFFFFFF;
      endcase
    end
    return {(v >= V_SYNC), (h >= H_SYNC), de_e, (h == 0 && v == 0), p};
  endfunction

  function automatic logic [27:0] exp2(input int n);
    int h, v, x, y;
    logic de_e;
    logic [23:0] p;
    h = n % C_H_TOTAL;
    v = (n / C_H_TOTAL) % C_V_TOTAL;
    x = h - (C_H_SYNC + C_H_BACKP);
    y = v - (C_V_SYNC + C_V_BACKP);
    de_e = (x >= 0) && (x < C_H_ACTIVE) && (y >= 0) && (y < C_V_ACTIVE);
    p = 24'h0;
    if (de_e) p = ((((x / 32) + (y / 32)) % 2) == 1) ? 24'h000000 : 24'hFFFFFF;
    return {(v >= C_V_SYNC), (h >= C_H_SYNC), de_e, (h == 0 && v == 0), p};
  endfunction

  // One clock; leaves the bench just after the falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    n1++;
    n2++;
    if (n1 >= 0 && (n1 % FRAME) == 0) begin
      f_pat = pattern_sel;
      f_col = solid_color;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; enable2 = 1'b0;
    pattern_sel = 2'd0; solid_color = 24'h0;
    pattern_sel2 = 2'd3; solid_color2 = 24'h0;
    n1 = -100000; n2 = -100000;
    f_pat = 2'd0; f_col = 24'h0;
    repeat (3) tick();
    compared++;
    if ({vsync, hsync, de, frame_top, pixel} !== IDLE) begin
      mismatched++;
      $display("FAIL reset_idle got %h exp %h", {vsync, hsync, de, frame_top, pixel}, IDLE);
    end
    compared++;
    if ({vsync2, hsync2, de2, frame_top2, pixel2} !== IDLE) begin
      mismatched++;
      $display("FAIL reset_idle_chk got %h exp %h", {vsync2, hsync2, de2, frame_top2, pixel2}, IDLE);
    end
    enable = 1'b1;
    repeat (2) tick();
    compared++;
    if ({vsync, hsync, de, frame_top, pixel} !== IDLE) begin
      mismatched++;
      $display("FAIL reset_holds_enable got %h exp %h", {vsync, hsync, de, frame_top, pixel}, IDLE);
    end
    enable = 1'b0;
  endtask

  task automatic test_checker();
    reset = 1'b0;
    enable2 = 1'b1;
    n2 = -1;
    for (int i = 0; i < C_FRAME; i++) begin
      tick();
      e = exp2(n2);
      compared++;
      if ({vsync2, hsync2, de2, frame_top2, pixel2} !== e) begin
        mismatched++;
        $display("FAIL checker n=%0d got %h exp %h", n2, {vsync2, hsync2, de2, frame_top2, pixel2}, e);
      end
    end
    enable2 = 1'b0;
    tick();
    compared++;
    if ({vsync2, hsync2, de2, frame_top2, pixel2} !== IDLE) begin
      mismatched++;
      $display("FAIL checker_stop got %h exp %h", {vsync2, hsync2, de2, frame_top2, pixel2}, IDLE);
    end
  endtask

  task automatic test_timing();
    int ft_cnt, hs_low, vs_low, de_hi;
    ft_cnt = 0; hs_low = 0; vs_low = 0; de_hi = 0;
    reset = 1'b1; enable = 1'b1; pattern_sel = 2'd0;
    tick();
    reset = 1'b0;
    n1 = -1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (i == 0) begin
        compared++;
        if (frame_top !== 1'b1) begin
          mismatched++;
          $display("FAIL first_frame_top got %b exp 1", frame_top);
        end
      end
      e = exp1(n1, f_pat, f_col);
      compared++;
      if ({vsync, hsync, de, frame_top, pixel} !== e) begin
        mismatched++;
        $display("FAIL timing_bars n=%0d got %h exp %h", n1, {vsync, hsync, de, frame_top, pixel}, e);
      end
      if (frame_top === 1'b1) ft_cnt++;
      if (hsync === 1'b0) hs_low++;
      if (vsync === 1'b0) vs_low++;
      if (de === 1'b1) de_hi++;
    end
    compared++;
    if (ft_cnt !== 2) begin mismatched++; $display("FAIL frame_top_count got %0d exp 2", ft_cnt); end
    compared++;
    if (hs_low !== 40) begin mismatched++; $display("FAIL hsync_low_count got %0d exp 40", hs_low); end
    compared++;
    if (vs_low !== 40) begin mismatched++; $display("FAIL vsync_low_count got %0d exp 40", vs_low); end
    compared++;
    if (de_hi !== 192) begin mismatched++; $display("FAIL de_count got %0d exp 192", de_hi); end
  endtask

  task automatic test_pattern_switch();
    int sw_frame, last, solid_cur, solid_next;
    solid_cur = 0; solid_next = 0;
    while ((n1 % FRAME) != 50) begin
      tick();
      e = exp1(n1, f_pat, f_col);
      compared++;
      if ({vsync, hsync, de, frame_top, pixel} !== e) begin
        mismatched++;
        $display("FAIL switch_pre n=%0d got %h exp %h", n1, {vsync, hsync, de, frame_top, pixel}, e);
      end
    end
    pattern_sel = 2'd2;
    solid_color = 24'h123456;
    sw_frame = n1 / FRAME;
    last = (sw_frame + 2) * FRAME - 1;
    while (n1 < last) begin
      tick();
      e = exp1(n1, f_pat, f_col);
      compared++;
      if ({vsync, hsync, de, frame_top, pixel} !== e) begin
        mismatched++;
        $display("FAIL switch n=%0d got %h exp %h", n1, {vsync, hsync, de, frame_top, pixel}, e);
      end
      if (pixel === 24'h123456) begin
        if (n1 / FRAME == sw_frame) solid_cur++;
        else solid_next++;
      end
    end
    compared++;
    if (solid_cur !== 0) begin mismatched++; $display("FAIL switch_same_frame got %0d exp 0", solid_cur); end
    compared++;
    if (solid_next !== 96) begin mismatched++; $display("FAIL switch_next_frame got %0d exp 96", solid_next); end
  endtask

  task automatic test_ramp();
    int last;
    pattern_sel = 2'd1;
    last = (n1 / FRAME + 2) * FRAME - 1;
    while (n1 < last) begin
      tick();
      e = exp1(n1, f_pat, f_col);
      compared++;
      if ({vsync, hsync, de, frame_top, pixel} !== e) begin
        mismatched++;
        $display("FAIL ramp n=%0d got %h exp %h", n1, {vsync, hsync, de, frame_top, pixel}, e);
      end
    end
  endtask

  task automatic test_enable_drop();
    pattern_sel = 2'd0;
    while ((n1 % FRAME) != 86) begin
      tick();
      e = exp1(n1, f_pat, f_col);
      compared++;
      if ({vsync, hsync, de, frame_top, pixel} !== e) begin
        mismatched++;
        $display("FAIL drop_pre n=%0d got %h exp %h", n1, {vsync, hsync, de, frame_top, pixel}, e);
      end
    end
    enable = 1'b0;
    n1 = -100000;
    for (int i = 0; i < 5; i++) begin
      tick();
      compared++;
      if ({vsync, hsync, de, frame_top, pixel} !== IDLE) begin
        mismatched++;
        $display("FAIL drop_idle i=%0d got %h exp %h", i, {vsync, hsync, de, frame_top, pixel}, IDLE);
      end
    end
    enable = 1'b1;
    n1 = -1;
    tick();
    compared++;
    if (frame_top !== 1'b1) begin
      mismatched++;
      $display("FAIL reenable_frame_top got %b exp 1", frame_top);
    end
    for (int i = 0; i < FRAME; i++) begin
      e = exp1(n1, f_pat, f_col);
      compared++;
      if ({vsync, hsync, de, frame_top, pixel} !== e) begin
        mismatched++;
        $display("FAIL reenable n=%0d got %h exp %h", n1, {vsync, hsync, de, frame_top, pixel}, e);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_line();
    while ((n1 % FRAME) != 70) begin
      tick();
    end
    compared++;
    if ({de, pixel} !== {1'b1, bars[3]}) begin
      mismatched++;
      $display("FAIL mid_line_active got %h exp %h", {de, pixel}, {1'b1, bars[3]});
    end
    reset = 1'b1;
    #1;
    compared++;
    if ({vsync, hsync, de, frame_top, pixel} !== IDLE) begin
      mismatched++;
      $display("FAIL async_reset got %h exp %h", {vsync, hsync, de, frame_top, pixel}, IDLE);
    end
    n1 = -100000;
    repeat (2) tick();
    reset = 1'b0;
    n1 = -1;
    tick();
    compared++;
    if (frame_top !== 1'b1) begin
      mismatched++;
      $display("FAIL post_reset_frame_top got %b exp 1", frame_top);
    end
    for (int i = 0; i < FRAME; i++) begin
      e = exp1(n1, f_pat, f_col);
      compared++;
      if ({vsync, hsync, de, frame_top, pixel} !== e) begin
        mismatched++;
        $display("FAIL post_reset n=%0d got %h exp %h", n1, {vsync, hsync, de, frame_top, pixel}, e);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_checker();
    test_timing();
    test_pattern_switch();
    test_ramp();
    test_enable_drop();
    test_reset_mid_line();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
